outlier_collector_arbiter: RTL and testbench
============================================

Name: outlier_collector_arbiter

Overview:
Shares the single outlier-FIFO write port among CORE_NUMBER validator cores. Round-robin arbiter accepts one finished core result per cycle and acknowledges it so the controller can reload that core. Outlier point indices are packed two per 2N-bit FIFO word. A flush drains and pads the last half word at end of cloud, and per-cloud inlier/outlier counts are kept.

Parameters:
N, 16, point-index width; FIFO word is 2N.
CORE_NUMBER, 16, number of requesting cores; power of two, 2..64.

Ports:
clock  in  1  rising-edge clock
reset  in  1  synchronous, active-low
core_done  in  CORE_NUMBER  bit i: core i has a result; held until core_ack[i]
core_outlier  in  CORE_NUMBER  bit i: result of core i is outlier (valid with core_done[i])
core_pos  in  N*CORE_NUMBER  slice i: point index under test in core i
core_ack  out  CORE_NUMBER  one-hot, one-cycle accept pulse
fifo_din  out  2N  packed word {first_idx, second_idx}
fifo_wr_en  out  1  write strobe
fifo_full  in  1  FIFO full
flush  in  1  one-cycle end-of-cloud request
done  out  1  level; flush complete
outlier_count  out  N  outliers accepted this cloud
inlier_count  out  N  inliers accepted this cloud

Behaviour:
- Reset (reset==0 at edge): core_ack=0, fifo_wr_en=0, fifo_din=0, done=0, counts=0, rr_ptr=0, half_valid=0, pend_valid=0, state=RUN. Reset mid-operation discards the held half word and the pending word.
- States: RUN, DRAIN, PAD, DONE.
- Arbitration (RUN only):
  - Eligible set = core_done & ~core_ack. This masks the core acked this cycle, which still shows done.
  - Winner = first eligible index searching upward from rr_ptr, with wrap-around.
  - On grant, registered: core_ack[winner]=1 next cycle; rr_ptr<=winner+1 mod CORE_NUMBER. At most one grant per cycle.
  - Stall: no grant in a cycle where pend_valid & half_valid. Nothing wins while stalled; rr_ptr is unchanged.
- Accept path (same edge as grant):
  - Inlier: inlier_count+1.
  - Outlier: outlier_count+1; idx=core_pos slice winner.
    - If half_valid=0: half<=idx, half_valid<=1.
    - Else: pend<={half,idx}, pend_valid<=1, half_valid<=0.
  - Counters saturate at 2^N-1.
- FIFO write: fifo_din=pend (register). fifo_wr_en = pend_valid & ~fifo_full (combinational). pend_valid clears on that edge. A new pend may load on the same edge the old one drains.
- Latency: a second outlier accepted at edge t is presented on fifo_din from t+1. fifo_wr_en asserts in the same cycle if the FIFO is not full.
- flush in RUN:
  - State->DRAIN at the next edge.
  - A grant decided in the flush cycle still completes.
  - No grants after that edge. core_done requests are ignored and left unacked.
- DRAIN: wait pend_valid=0. Then if half_valid, go to PAD, else go to DONE.
- PAD: pend<={half,{N{1'b1}}}, pend_valid<=1, half_valid<=0. Wait for it to drain, then go to DONE. 0xFFFF (all ones) is the padding sentinel.
- DONE: done=1 (level); no grants, no writes. Leave only by reset. flush in DRAIN/PAD/DONE is ignored.
- fifo_full held indefinitely: pending word retained; the design never drops or duplicates an index.

Test Plan:
- Cores 3 and 7 done simultaneously, both inliers, rr_ptr=0 -> core_ack[3] at t+1, core_ack[7] at t+2; inlier_count=2; fifo_wr_en never asserted.
- Cores 0,1 outliers, pos 0x0005 and 0x0009 -> one write fifo_din=0x00050009; outlier_count=2.
- All 16 cores held done continuously for 32 cycles -> acks rotate 0..15 then 0..15; no core acked on two consecutive cycles.
- fifo_full=1 while 4 outliers (pos 1,2,3,4) arrive -> pend=0x00010002 held; half=3; grants stall; on fifo_full=0, writes 0x00010002 then 0x00030004 in order, with no loss.
- Three outliers (pos 0x10,0x11,0x12) then flush -> writes 0x00100011, then 0x0012FFFF; done rises the cycle after the last write.
- reset low in PAD state -> all outputs reset values next edge; no padded word written.

Source files
------------

// File: rtl/outlier_collector_arbiter_if.sv
// rtl/outlier_collector_arbiter_if.sv - core request bus and outlier FIFO write port
interface outlier_collector_arbiter_if #(
   parameter int N           = 16,
   parameter int CORE_NUMBER = 16
);
   logic [CORE_NUMBER-1:0]   core_done;
   logic [CORE_NUMBER-1:0]   core_outlier;
   logic [N*CORE_NUMBER-1:0] core_pos;
   logic [CORE_NUMBER-1:0]   core_ack;
   logic [2*N-1:0]           fifo_din;
   logic                     fifo_wr_en;
   logic                     fifo_full;
   logic                     flush;
   logic                     done;
   logic [N-1:0]             outlier_count;
   logic [N-1:0]             inlier_count;

   // collector side: takes core results, owns the FIFO write port
   modport slave (
      input  core_done, core_outlier, core_pos, fifo_full, flush,
      output core_ack, fifo_din, fifo_wr_en, done, outlier_count, inlier_count
   );

   // environment side: cores, FIFO and cloud controller
   modport master (
      output core_done, core_outlier, core_pos, fifo_full, flush,
      input  core_ack, fifo_din, fifo_wr_en, done, outlier_count, inlier_count
   );
endinterface

// File: rtl/outlier_collector_arbiter.sv
// rtl/outlier_collector_arbiter.sv - round-robin collector packing outlier indices into the FIFO
module outlier_collector_arbiter #(
   parameter int N           = 16,
   parameter int CORE_NUMBER = 16
) (
   input  logic                        clock,
   input  logic                        reset,
   outlier_collector_arbiter_if.slave  bus
);
   localparam int PW = $clog2(CORE_NUMBER);

   typedef enum logic [1:0] {RUN, DRAIN, PAD, DONE} state_t;

   state_t                 state;
   state_t                 state_next;
   logic [PW-1:0]          rr_ptr;
   logic [PW-1:0]          winner;
   logic [PW-1:0]          idx;
   logic                   any_eligible;
   logic [CORE_NUMBER-1:0] eligible;
   logic                   grant;
   logic                   pad_load;
   logic                   write_now;
   logic [N-1:0]           win_pos;
   logic                   win_outlier;
   logic [N-1:0]           half;
   logic                   half_valid;
   logic [2*N-1:0]         pend;
   logic                   pend_valid;
   logic [CORE_NUMBER-1:0] core_ack_r;
   logic [N-1:0]           outlier_cnt;
   logic [N-1:0]           inlier_cnt;

   assign bus.core_ack      = core_ack_r;
   assign bus.fifo_din      = pend;
   assign bus.outlier_count = outlier_cnt;
   assign bus.inlier_count  = inlier_cnt;

   // Round-robin pick: scan downward in offset so the closest index above rr_ptr wins last.
   // The core acked this cycle still shows done, so it is masked out.
   always_comb begin
      eligible     = bus.core_done & ~core_ack_r;
      winner       = rr_ptr;
      idx          = rr_ptr;
      any_eligible = 1'b0;
      for (int i = CORE_NUMBER - 1; i >= 0; i--) begin
         idx = rr_ptr + PW'(i);
         if (eligible[idx]) begin
            winner       = idx;
            any_eligible = 1'b1;
         end
      end
      win_pos     = bus.core_pos[int'(winner)*N +: N];
      win_outlier = bus.core_outlier[winner];
   end

   // State register
   always_ff @(posedge clock) begin
      if (!reset) state <= RUN;
      else        state <= state_next;
   end

   // Next state: DRAIN waits for the pending word, PAD finishes on the edge its word is written
   always_comb begin
      state_next = state;
      case (state)
         RUN:   if (bus.flush) state_next = DRAIN;
         DRAIN: if (!pend_valid) state_next = half_valid ? PAD : DONE;
         PAD:   if (!half_valid && (!pend_valid || write_now)) state_next = DONE;
         DONE:  state_next = DONE;
         default: state_next = RUN;
      endcase
   end

   // FSM outputs: grants only in RUN and not while both half and pending words are occupied
   always_comb begin
      grant         = (state == RUN) && !(pend_valid && half_valid) && any_eligible;
      pad_load      = (state == PAD) && half_valid && !pend_valid;
      write_now     = pend_valid && !bus.fifo_full;
      bus.fifo_wr_en = write_now;
      bus.done      = (state == DONE);
   end

   // Accept path: ack pulse, pointer advance, counters and two-per-word packing
   always_ff @(posedge clock) begin
      if (!reset) begin
         core_ack_r  <= '0;
         rr_ptr      <= '0;
         half        <= '0;
         half_valid  <= 1'b0;
         pend        <= '0;
         pend_valid  <= 1'b0;
         outlier_cnt <= '0;
         inlier_cnt  <= '0;
      end else begin
         core_ack_r <= '0;
         if (write_now) pend_valid <= 1'b0;
         if (grant) begin
            core_ack_r[winner] <= 1'b1;
            rr_ptr             <= winner + 1'b1;
            if (win_outlier) begin
               if (outlier_cnt != {N{1'b1}}) outlier_cnt <= outlier_cnt + 1'b1;
               if (half_valid) begin
                  pend       <= {half, win_pos};
                  pend_valid <= 1'b1;
                  half_valid <= 1'b0;
               end else begin
                  half       <= win_pos;
                  half_valid <= 1'b1;
               end
            end else begin
               if (inlier_cnt != {N{1'b1}}) inlier_cnt <= inlier_cnt + 1'b1;
            end
         end else if (pad_load) begin
            pend       <= {half, {N{1'b1}}};
            pend_valid <= 1'b1;
            half_valid <= 1'b0;
         end
      end
   end
endmodule

// File: tb/tb_outlier_collector_arbiter.sv
// tb/tb_outlier_collector_arbiter.sv - scoreboard bench for the outlier collector arbiter
module tb_outlier_collector_arbiter;
   logic clock;
   logic reset;
   int   n_cmp;
   int   n_bad;
   int   cyc;
   int   last_wr_cyc;
   bit   hold_all;
   logic [31:0] exp_word;
   logic [31:0] exp_q[$];

   outlier_collector_arbiter_if #(.N(16), .CORE_NUMBER(16)) bus ();

   outlier_collector_arbiter #(.N(16), .CORE_NUMBER(16)) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   initial begin
      #400000;
      $display("FAIL watchdog: simulation still running, required finish");
      $fatal(1);
   end

   // one clock: check the write about to happen against the scoreboard, then advance
   task automatic tick();
      #1;
      if (bus.fifo_wr_en === 1'b1) begin
         n_cmp++;
         last_wr_cyc = cyc;
         if (exp_q.size() == 0) begin
            n_bad++;
            $display("FAIL fifo_write: got unexpected word %h, required no write", bus.fifo_din);
         end else begin
            exp_word = exp_q.pop_front();
            if (bus.fifo_din !== exp_word) begin
               n_bad++;
               $display("FAIL fifo_din: got %h, required %h", bus.fifo_din, exp_word);
            end
         end
      end
      @(negedge clock);
      cyc++;
      if (!hold_all) bus.core_done = bus.core_done & ~bus.core_ack;
   endtask

   task automatic wait_drained(output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 40; i++) begin
         if (exp_q.size() == 0) begin
            ok = 1'b1;
            break;
         end
         tick();
      end
   endtask

   task automatic apply_reset();
      reset            = 1'b0;
      hold_all         = 1'b0;
      bus.core_done    = '0;
      bus.core_outlier = '0;
      bus.core_pos     = '0;
      bus.fifo_full    = 1'b0;
      bus.flush        = 1'b0;
      tick();
      tick();
      reset = 1'b1;
   endtask

   task automatic test_reset();
      apply_reset();
      n_cmp++; if (bus.core_ack !== 16'h0) begin n_bad++; $display("FAIL reset_ack: got %h, required 0000", bus.core_ack); end
      n_cmp++; if (bus.fifo_wr_en !== 1'b0) begin n_bad++; $display("FAIL reset_wr_en: got %b, required 0", bus.fifo_wr_en); end
      n_cmp++; if (bus.fifo_din !== 32'h0) begin n_bad++; $display("FAIL reset_din: got %h, required 0", bus.fifo_din); end
      n_cmp++; if (bus.done !== 1'b0) begin n_bad++; $display("FAIL reset_done: got %b, required 0", bus.done); end
      n_cmp++; if (bus.outlier_count !== 16'h0) begin n_bad++; $display("FAIL reset_outliers: got %0d, required 0", bus.outlier_count); end
      n_cmp++; if (bus.inlier_count !== 16'h0) begin n_bad++; $display("FAIL reset_inliers: got %0d, required 0", bus.inlier_count); end
   endtask

   task automatic test_inliers();
      apply_reset();
      bus.core_done = 16'h0088;
      tick();
      n_cmp++; if (bus.core_ack !== 16'h0008) begin n_bad++; $display("FAIL inlier_ack3: got %h, required 0008", bus.core_ack); end
      tick();
      n_cmp++; if (bus.core_ack !== 16'h0080) begin n_bad++; $display("FAIL inlier_ack7: got %h, required 0080", bus.core_ack); end
      tick();
      n_cmp++; if (bus.core_ack !== 16'h0000) begin n_bad++; $display("FAIL inlier_ack_idle: got %h, required 0000", bus.core_ack); end
      n_cmp++; if (bus.inlier_count !== 16'd2) begin n_bad++; $display("FAIL inlier_count: got %0d, required 2", bus.inlier_count); end
      n_cmp++; if (bus.outlier_count !== 16'd0) begin n_bad++; $display("FAIL inlier_outliers: got %0d, required 0", bus.outlier_count); end
   endtask

   task automatic test_pair_outliers();
      bit ok;
      apply_reset();
      bus.core_outlier    = 16'h0003;
      bus.core_pos[15:0]  = 16'h0005;
      bus.core_pos[31:16] = 16'h0009;
      bus.core_done       = 16'h0003;
      exp_q.push_back(32'h0005_0009);
      wait_drained(ok);
      tick();
      n_cmp++; if (!ok) begin n_bad++; $display("FAIL pair_drain: got %0d words left, required 0", exp_q.size()); end
      n_cmp++; if (bus.outlier_count !== 16'd2) begin n_bad++; $display("FAIL pair_count: got %0d, required 2", bus.outlier_count); end
   endtask

   task automatic test_round_robin();
      logic [15:0] exp_ack;
      logic [15:0] prev_ack;
      apply_reset();
      hold_all      = 1'b1;
      bus.core_done = 16'hFFFF;
      prev_ack      = 16'h0;
      for (int k = 0; k < 32; k++) begin
         tick();
         exp_ack = 16'h0001 << (k % 16);
         n_cmp++;
         if (bus.core_ack !== exp_ack) begin
            n_bad++;
            $display("FAIL rr_ack[%0d]: got %h, required %h", k, bus.core_ack, exp_ack);
         end
         n_cmp++;
         if (bus.core_ack === prev_ack) begin
            n_bad++;
            $display("FAIL rr_repeat[%0d]: got %h twice, required a different core", k, bus.core_ack);
         end
         prev_ack = bus.core_ack;
      end
      bus.core_done = '0;
      hold_all      = 1'b0;
      tick();
      tick();
      n_cmp++; if (bus.inlier_count !== 16'd32) begin n_bad++; $display("FAIL rr_count: got %0d, required 32", bus.inlier_count); end
   endtask

   task automatic test_full_stall();
      bit ok;
      int acks;
      apply_reset();
      bus.fifo_full    = 1'b1;
      bus.core_outlier = 16'h000F;
      for (int i = 0; i < 4; i++) bus.core_pos[i*16 +: 16] = 16'(i + 1);
      bus.core_done    = 16'h000F;
      exp_q.push_back(32'h0001_0002);
      exp_q.push_back(32'h0003_0004);
      acks = 0;
      for (int i = 0; i < 10; i++) begin
         tick();
         if (bus.core_ack != 16'h0) acks++;
      end
      n_cmp++; if (acks != 3) begin n_bad++; $display("FAIL stall_acks: got %0d, required 3", acks); end
      n_cmp++; if (bus.fifo_din !== 32'h0001_0002) begin n_bad++; $display("FAIL stall_pend: got %h, required 00010002", bus.fifo_din); end
      n_cmp++; if (bus.fifo_wr_en !== 1'b0) begin n_bad++; $display("FAIL stall_wr_en: got %b, required 0", bus.fifo_wr_en); end
      n_cmp++; if (bus.outlier_count !== 16'd3) begin n_bad++; $display("FAIL stall_count: got %0d, required 3", bus.outlier_count); end
      bus.fifo_full = 1'b0;
      wait_drained(ok);
      tick();
      n_cmp++; if (!ok) begin n_bad++; $display("FAIL stall_drain: got %0d words left, required 0", exp_q.size()); end
      n_cmp++; if (bus.outlier_count !== 16'd4) begin n_bad++; $display("FAIL stall_final: got %0d, required 4", bus.outlier_count); end
   endtask

   task automatic test_flush_pad();
      bit seen;
      apply_reset();
      bus.core_outlier = 16'h0007;
      for (int i = 0; i < 3; i++) bus.core_pos[i*16 +: 16] = 16'(16'h0010 + i);
      bus.core_done    = 16'h0007;
      exp_q.push_back(32'h0010_0011);
      exp_q.push_back(32'h0012_FFFF);
      repeat (4) tick();
      bus.flush = 1'b1;
      tick();
      bus.flush = 1'b0;
      seen = 1'b0;
      for (int i = 0; i < 30; i++) begin
         tick();
         if (bus.done === 1'b1) begin
            seen = 1'b1;
            break;
         end
      end
      n_cmp++; if (!seen) begin n_bad++; $display("FAIL flush_done: got done=%b, required 1 within 30 cycles", bus.done); end
      n_cmp++; if (cyc != last_wr_cyc + 1) begin n_bad++; $display("FAIL flush_done_timing: got cycle %0d, required %0d", cyc, last_wr_cyc + 1); end
      n_cmp++; if (exp_q.size() != 0) begin n_bad++; $display("FAIL flush_words: got %0d words left, required 0", exp_q.size()); end
      n_cmp++; if (bus.outlier_count !== 16'd3) begin n_bad++; $display("FAIL flush_count: got %0d, required 3", bus.outlier_count); end
      bus.flush            = 1'b1;
      bus.core_outlier[5]  = 1'b1;
      bus.core_done        = 16'h0020;
      tick();
      bus.flush = 1'b0;
      for (int i = 0; i < 4; i++) begin
         tick();
         n_cmp++; if (bus.core_ack !== 16'h0) begin n_bad++; $display("FAIL done_ack[%0d]: got %h, required 0000", i, bus.core_ack); end
         n_cmp++; if (bus.done !== 1'b1) begin n_bad++; $display("FAIL done_level[%0d]: got %b, required 1", i, bus.done); end
      end
      bus.core_done = '0;
   endtask

   task automatic test_reset_in_pad();
      apply_reset();
      bus.core_outlier   = 16'h0001;
      bus.core_pos[15:0] = 16'h0020;
      bus.core_done      = 16'h0001;
      tick();
      bus.flush = 1'b1;
      tick();
      bus.flush = 1'b0;
      tick();
      n_cmp++; if (bus.outlier_count !== 16'd1) begin n_bad++; $display("FAIL pad_pre_count: got %0d, required 1", bus.outlier_count); end
      reset = 1'b0;
      tick();
      n_cmp++; if (bus.fifo_wr_en !== 1'b0) begin n_bad++; $display("FAIL pad_reset_wr_en: got %b, required 0", bus.fifo_wr_en); end
      n_cmp++; if (bus.fifo_din !== 32'h0) begin n_bad++; $display("FAIL pad_reset_din: got %h, required 0", bus.fifo_din); end
      n_cmp++; if (bus.outlier_count !== 16'd0) begin n_bad++; $display("FAIL pad_reset_count: got %0d, required 0", bus.outlier_count); end
      n_cmp++; if (bus.done !== 1'b0) begin n_bad++; $display("FAIL pad_reset_done: got %b, required 0", bus.done); end
      reset = 1'b1;
      for (int i = 0; i < 5; i++) begin
         tick();
         n_cmp++; if (bus.fifo_wr_en !== 1'b0) begin n_bad++; $display("FAIL pad_after_wr_en[%0d]: got %b, required 0", i, bus.fifo_wr_en); end
         n_cmp++; if (bus.done !== 1'b0) begin n_bad++; $display("FAIL pad_after_done[%0d]: got %b, required 0", i, bus.done); end
      end
   endtask

   initial begin
      n_cmp       = 0;
      n_bad       = 0;
      cyc         = 0;
      last_wr_cyc = -10;
      hold_all    = 1'b0;
      reset       = 1'b0;
      test_reset();
      test_inliers();
      test_pair_outliers();
      test_round_robin();
      test_full_stall();
      test_flush_pad();
      test_reset_in_pad();
      n_cmp++;
      if (exp_q.size() != 0) begin
         n_bad++;
         $display("FAIL scoreboard_leftover: got %0d words unwritten, required 0", exp_q.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
